// File: rtl/dm_cache_controller_if.sv
// CPU-side request/response and memory-side block-read/word-write signals of the
// direct-mapped cache controller, bundled for connection between CPU, cache and memory.
interface dm_cache_controller_if #(
  parameter int ADDR_W = 32,
  parameter int WORD_W = 32
);
  logic                  cpu_read;
  logic                  cpu_write;
  logic [ADDR_W-1:0]     cpu_address;
  logic [WORD_W-1:0]     cpu_write_data;
  logic [WORD_W-1:0]     cpu_read_data;
  logic                  cpu_ready;
  logic                  mem_read;
  logic                  mem_write;
  logic [ADDR_W-1:0]     mem_address;
  logic [WORD_W-1:0]     mem_write_data;
  logic [4*WORD_W-1:0]   mem_read_data;

  // Cache controller view
  modport slave (
    input  cpu_read, cpu_write, cpu_address, cpu_write_data, mem_read_data,
    output cpu_read_data, cpu_ready, mem_read, mem_write, mem_address, mem_write_data
  );

  // CPU + data memory view
  modport master (
    output cpu_read, cpu_write, cpu_address, cpu_write_data, mem_read_data,
    input  cpu_read_data, cpu_ready, mem_read, mem_write, mem_address, mem_write_data
  );
endinterface

// File: rtl/dm_cache_controller.sv
// Direct-mapped, write-through, no-write-allocate cache with 4-word lines,
// zero-latency read hits, block fills on read misses and access/hit statistics.
module dm_cache_controller #(
  parameter int ADDR_W      = 32,
  parameter int WORD_W      = 32,
  parameter int NUM_SETS    = 1024,
  parameter int MEM_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  dm_cache_controller_if.slave  bus,
  output logic [31:0]           access_count,
  output logic [31:0]           hit_count
);

  localparam int INDEX_W = $clog2(NUM_SETS);
  localparam int TAG_W   = ADDR_W - 2 - INDEX_W;
  localparam int CNT_W   = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

  state_t               state;
  logic [CNT_W-1:0]     lat_cnt;
  logic                 miss_seen;
  logic [NUM_SETS-1:0]  valid;
  logic [TAG_W-1:0]     tag_mem  [NUM_SETS];
  logic [WORD_W-1:0]    data_mem [NUM_SETS][4];

  logic [1:0]           offset;
  logic [INDEX_W-1:0]   index;
  logic [TAG_W-1:0]     tag;
  logic                 is_read;
  logic                 is_write;
  logic                 hit;
  logic                 fill_done;
  logic                 ready_c;
  logic                 done;

  assign offset    = bus.cpu_address[1:0];
  assign index     = bus.cpu_address[2 +: INDEX_W];
  assign tag       = bus.cpu_address[ADDR_W-1 -: TAG_W];
  assign is_write  = bus.cpu_write;
  assign is_read   = bus.cpu_read & ~bus.cpu_write;
  assign hit       = valid[index] && (tag_mem[index] == tag);
  assign fill_done = (state == FILL) && (lat_cnt == '0);

  always_comb begin
    ready_c = 1'b1;
    unique case (state)
      IDLE:    ready_c = !is_write && !(is_read && !hit);
      FILL:    ready_c = 1'b0;
      WRITE:   ready_c = 1'b1;
      default: ready_c = 1'b1;
    endcase
  end

  assign done = (is_read || is_write) && ready_c;

  // Reset forces the idle response immediately, even with a request held.
  assign bus.cpu_ready      = ~rst | ready_c;
  assign bus.cpu_read_data  = (is_read && hit) ? data_mem[index][offset] : '0;
  assign bus.mem_read       = (state == FILL);
  assign bus.mem_write      = (state == WRITE);
  assign bus.mem_address    = (state == FILL) ? {bus.cpu_address[ADDR_W-1:2], 2'b00}
                                              : bus.cpu_address;
  assign bus.mem_write_data = bus.cpu_write_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      lat_cnt      <= '0;
      miss_seen    <= 1'b0;
      valid        <= '0;
      access_count <= '0;
      hit_count    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (is_write) begin
            state <= WRITE;
          end else if (is_read && !hit) begin
            state   <= FILL;
            lat_cnt <= CNT_W'(MEM_LATENCY - 1);
          end
        end
        FILL: begin
          if (lat_cnt == '0) begin
            state        <= IDLE;
            valid[index] <= 1'b1;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        WRITE:   state <= IDLE;
        default: state <= IDLE;
      endcase

      // miss_seen keeps the completing re-lookup of a filled line out of hit_count.
      if (done) begin
        miss_seen <= 1'b0;
        if (access_count != '1) access_count <= access_count + 1'b1;
        if (hit && !miss_seen && hit_count != '1) hit_count <= hit_count + 1'b1;
      end else if (state == IDLE && is_read && !hit) begin
        miss_seen <= 1'b1;
      end
    end
  end

  // Tag/data arrays carry no reset; valid bits alone qualify them.
  always_ff @(posedge clk) begin
    if (fill_done) begin
      tag_mem[index] <= tag;
      for (int unsigned k = 0; k < 4; k++) begin
        data_mem[index][k[1:0]] <= bus.mem_read_data[k*WORD_W +: WORD_W];
      end
    end else if (bus.mem_write && hit) begin
      data_mem[index][offset] <= bus.cpu_write_data;
    end
  end

endmodule

// File: tb/tb_dm_cache_controller.sv
// Bench for dm_cache_controller: transaction-level cache/memory model predicts every
// cycle of each request; a latency-honouring memory emulation serves the DUT.
module tb_dm_cache_controller;

  localparam int NS = 1024;
  localparam int L  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] acc_cnt;
  logic [31:0] hit_cnt;

  dm_cache_controller_if #(.ADDR_W(32), .WORD_W(32)) bus ();

  dm_cache_controller #(
    .ADDR_W(32), .WORD_W(32), .NUM_SETS(NS), .MEM_LATENCY(L)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .access_count(acc_cnt), .hit_count(hit_cnt)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic bit [31:0] init_word(input bit [31:0] a);
    if (a >= 32'h400 && a <= 32'h23FF) return a;
    return a ^ 32'hA5A5_5A5A;
  endfunction

  // Reference model: cache contents, memory image and counters.
  bit          m_valid [NS];
  bit [31:0]   m_tag   [NS];
  bit [31:0]   m_line  [NS][4];
  bit [31:0]   m_mem   [bit [31:0]];
  bit [31:0]   m_acc = 0;
  bit [31:0]   m_hit = 0;

  function automatic bit [31:0] model_rd(input bit [31:0] a);
    if (m_mem.exists(a)) return m_mem[a];
    return init_word(a);
  endfunction

  function automatic bit [31:0] inc(input bit [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 1;
  endfunction

  typedef struct packed {
    logic        ready;
    logic        mrd;
    logic        mwr;
    logic [31:0] maddr;
    logic [31:0] wd;
    logic [31:0] rdata;
    logic [31:0] acc;
    logic [31:0] hit;
  } exp_t;

  exp_t expq[$];
  bit   cmp_en = 1'b0;

  function automatic exp_t mk(input bit ready, input bit mrd, input bit mwr,
                              input bit [31:0] maddr, input bit [31:0] wd,
                              input bit [31:0] rdata);
    exp_t e;
    e.ready = ready; e.mrd = mrd; e.mwr = mwr; e.maddr = maddr;
    e.wd = wd; e.rdata = rdata; e.acc = m_acc; e.hit = m_hit;
    return e;
  endfunction

  // Memory emulation: block data is valid only on the L-th held cycle of mem_read.
  bit [31:0]   p_mem [bit [31:0]];
  int unsigned rd_run = 0;

  function automatic bit [31:0] phys_rd(input bit [31:0] a);
    if (p_mem.exists(a)) return p_mem[a];
    return init_word(a);
  endfunction

  always @(negedge clk) begin
    if (bus.mem_write) p_mem[bus.mem_address] = bus.mem_write_data;
    if (bus.mem_read) rd_run++;
    else rd_run = 0;
    for (int k = 0; k < 4; k++) begin
      bus.mem_read_data[k*32 +: 32] = (bus.mem_read && rd_run == L)
                                      ? phys_rd(bus.mem_address + k)
                                      : 32'hBAD0_0000 + k;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (cmp_en) begin
      if (expq.size() > 0) e = expq.pop_front();
      else e = mk(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
      chk("cpu_ready", {31'b0, bus.cpu_ready}, {31'b0, e.ready});
      chk("mem_read",  {31'b0, bus.mem_read},  {31'b0, e.mrd});
      chk("mem_write", {31'b0, bus.mem_write}, {31'b0, e.mwr});
      if (e.mrd || e.mwr) chk("mem_address", bus.mem_address, e.maddr);
      if (e.mwr) chk("mem_write_data", bus.mem_write_data, e.wd);
      chk("cpu_read_data", bus.cpu_read_data, e.rdata);
      chk("access_count", acc_cnt, e.acc);
      chk("hit_count", hit_cnt, e.hit);
    end
  end

  // Predicts the request's cycle-by-cycle behaviour, drives it, and reports what was seen.
  task automatic do_req(input bit wr, input bit [31:0] a, input bit [31:0] wd,
                        output bit [31:0] got, output int unsigned lows,
                        output int unsigned rds, output int unsigned wrs);
    int unsigned idx, off, n;
    bit          h;
    bit [31:0]   blk;
    idx = (a >> 2) % NS;
    off = a % 4;
    blk = a - off;
    h   = m_valid[idx] && (m_tag[idx] == (a >> 12));
    if (wr) begin
      expq.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0, wd, 32'h0));
      expq.push_back(mk(1'b1, 1'b0, 1'b1, a, wd, 32'h0));
      m_mem[a] = wd;
      if (h) m_line[idx][off] = wd;
      m_acc = inc(m_acc);
      if (h) m_hit = inc(m_hit);
      n = 2;
    end else if (h) begin
      expq.push_back(mk(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, m_line[idx][off]));
      m_acc = inc(m_acc);
      m_hit = inc(m_hit);
      n = 1;
    end else begin
      expq.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0));
      for (int k = 0; k < L; k++) expq.push_back(mk(1'b0, 1'b1, 1'b0, blk, 32'h0, 32'h0));
      m_valid[idx] = 1'b1;
      m_tag[idx]   = a >> 12;
      for (int k = 0; k < 4; k++) m_line[idx][k] = model_rd(blk + k);
      expq.push_back(mk(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, m_line[idx][off]));
      m_acc = inc(m_acc);
      n = L + 2;
    end

    bus.cpu_read       = !wr;
    bus.cpu_write      = wr;
    bus.cpu_address    = a;
    bus.cpu_write_data = wd;
    lows = 0; rds = 0; wrs = 0; got = 0;
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge clk);
      if (!bus.cpu_ready) lows++;
      if (bus.mem_read) rds++;
      if (bus.mem_write) wrs++;
      if (i == n - 1) got = bus.cpu_read_data;
      @(posedge clk);
    end
    #1;
    bus.cpu_read  = 1'b0;
    bus.cpu_write = 1'b0;
  endtask

  initial begin
    bit [31:0]   got;
    int unsigned lows, rds, wrs;

    bus.cpu_read = 1'b0; bus.cpu_write = 1'b0;
    bus.cpu_address = '0; bus.cpu_write_data = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_ready",     {31'b0, bus.cpu_ready}, 32'd1);
    chk("reset_mem_read",  {31'b0, bus.mem_read},  32'd0);
    chk("reset_mem_write", {31'b0, bus.mem_write}, 32'd0);
    chk("reset_access",    acc_cnt, 32'd0);
    chk("reset_hit",       hit_cnt, 32'd0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk) #1;
    cmp_en = 1'b1;

    do_req(1'b0, 32'h400, 32'h0, got, lows, rds, wrs);
    chk("t1_stall_cycles", lows, 32'd3);
    chk("t1_fill_cycles",  rds,  32'd2);
    chk("t1_data",         got,  32'h400);
    chk("t1_access",       acc_cnt, 32'd1);
    chk("t1_hit",          hit_cnt, 32'd0);

    do_req(1'b0, 32'h403, 32'h0, got, lows, rds, wrs);
    chk("t2_stall_cycles", lows, 32'd0);
    chk("t2_fill_cycles",  rds,  32'd0);
    chk("t2_data",         got,  32'h403);
    chk("t2_access",       acc_cnt, 32'd2);
    chk("t2_hit",          hit_cnt, 32'd1);

    do_req(1'b1, 32'h402, 32'hDEAD, got, lows, rds, wrs);
    chk("t3_write_pulses", wrs,  32'd1);
    chk("t3_stall_cycles", lows, 32'd1);
    do_req(1'b0, 32'h402, 32'h0, got, lows, rds, wrs);
    chk("t3_read_data",    got,  32'hDEAD);
    chk("t3_read_stall",   lows, 32'd0);

    do_req(1'b0, 32'h1400, 32'h0, got, lows, rds, wrs);
    chk("t4_conflict_fill", rds, 32'd2);
    chk("t4_conflict_data", got, 32'h1400);
    do_req(1'b0, 32'h400, 32'h0, got, lows, rds, wrs);
    chk("t4_refill",       rds, 32'd2);
    chk("t4_refill_data",  got, 32'h400);

    do_req(1'b1, 32'h800, 32'h55, got, lows, rds, wrs);
    chk("t5_no_allocate_fill", rds, 32'd0);
    chk("t5_write_pulses",     wrs, 32'd1);
    do_req(1'b0, 32'h800, 32'h0, got, lows, rds, wrs);
    chk("t5_read_stall",   lows, 32'd3);
    chk("t5_read_data",    got,  32'h55);
    chk("t5_access",       acc_cnt, 32'd8);
    chk("t5_hit",          hit_cnt, 32'd3);

    for (int unsigned r = 0; r < 250; r++) begin
      bit [31:0] a;
      a = ($urandom_range(0, 3) << 12) | ($urandom_range(32'h100, 32'h103) << 2)
          | $urandom_range(0, 3);
      do_req(($urandom_range(0, 9) < 3), a, $urandom, got, lows, rds, wrs);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    // Reset asserted in the last FILL cycle of a read miss for 0x500.
    cmp_en = 1'b0;
    bus.cpu_read = 1'b1;
    bus.cpu_address = 32'h500;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("t6_fill_active", {31'b0, bus.mem_read}, 32'd1);
    rst = 1'b0;
    #1;
    chk("t6_mem_read_drop", {31'b0, bus.mem_read},  32'd0);
    chk("t6_ready",         {31'b0, bus.cpu_ready}, 32'd1);
    chk("t6_read_data",     bus.cpu_read_data, 32'd0);
    chk("t6_access",        acc_cnt, 32'd0);
    chk("t6_hit",           hit_cnt, 32'd0);
    bus.cpu_read = 1'b0;
    for (int i = 0; i < NS; i++) m_valid[i] = 1'b0;
    m_acc = 0;
    m_hit = 0;
    @(negedge clk) rst = 1'b1;
    @(posedge clk) #1;
    cmp_en = 1'b1;
    do_req(1'b0, 32'h500, 32'h0, got, lows, rds, wrs);
    chk("t6_reread_stall", lows, 32'd3);
    chk("t6_reread_data",  got,  32'h500);
    chk("t6_reread_hit",   hit_cnt, 32'd0);

    repeat (3) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
